// File: rtl/demorgan_sweep_ctrl.sv
// demorgan_sweep_ctrl: self-test sequencer for the (~A)&(~B) De Morgan datapath.
// Sweeps every {A,B} operand pair, compares the sampled result against ~(A|B),
// counts mismatches and records the first failing vector.
// Optional feature macro: STOP_ON_FAIL_EN (end the sweep at the first mismatch).
module demorgan_sweep_ctrl #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNTW  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [WIDTH-1:0]     dp_a,
    output logic [WIDTH-1:0]     dp_b,
    input  logic [WIDTH-1:0]     dp_result,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      err_count,
    output logic [2*WIDTH-1:0]   fail_vec,
    output logic                 pass
);

    localparam int unsigned VW  = 2 * WIDTH;
    localparam int unsigned WCW = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } stateT;

    stateT            state, stateNxt;
    logic [VW-1:0]    vec, vecNxt;
    logic [WCW-1:0]   waitCnt, waitCntNxt;
    logic [WIDTH-1:0] dpANxt, dpBNxt;
    logic             busyNxt, doneNxt, passNxt;
    logic [CNTW-1:0]  errNxt, errInc;
    logic [VW-1:0]    failNxt;
    logic [WIDTH-1:0] golden;
    logic             mismatch;
    logic             lastVec;

    // Golden reference and compare against the sampled datapath result
    assign golden   = ~(dp_a | dp_b);
    assign mismatch = (dp_result != golden);

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vec       <= '0;
            waitCnt   <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= stateNxt;
            vec       <= vecNxt;
            waitCnt   <= waitCntNxt;
            dp_a      <= dpANxt;
            dp_b      <= dpBNxt;
            busy      <= busyNxt;
            done      <= doneNxt;
            err_count <= errNxt;
            fail_vec  <= failNxt;
            pass      <= passNxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNxt   = state;
        vecNxt     = vec;
        waitCntNxt = waitCnt;
        dpANxt     = dp_a;
        dpBNxt     = dp_b;
        busyNxt    = busy;
        doneNxt    = done;
        errNxt     = err_count;
        failNxt    = fail_vec;
        passNxt    = pass;
        errInc     = err_count;
        lastVec    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNxt = DRIVE;
                    vecNxt   = '0;
                    errNxt   = '0;
                    failNxt  = '0;
                    doneNxt  = 1'b0;
                    passNxt  = 1'b0;
                    busyNxt  = 1'b1;
                end
            end
            DRIVE: begin
                dpANxt     = vec[VW-1:WIDTH];
                dpBNxt     = vec[WIDTH-1:0];
                waitCntNxt = WCW'(LAT - 1);
                stateNxt   = WAIT;
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNxt = CHECK;
                end else begin
                    waitCntNxt = waitCnt - WCW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    // Saturating count; an empty count means this is the first failure
                    if (err_count != '1) begin
                        errInc = err_count + CNTW'(1);
                    end
                    if (err_count == '0) begin
                        failNxt = vec;
                    end
                end
                errNxt = errInc;
`ifdef STOP_ON_FAIL_EN
                lastVec = (vec == '1) || mismatch;
`else
                lastVec = (vec == '1);
`endif
                if (lastVec) begin
                    stateNxt = DONE;
                    busyNxt  = 1'b0;
                    doneNxt  = 1'b1;
                    passNxt  = (errInc == '0);
                end else begin
                    vecNxt   = vec + VW'(1);
                    stateNxt = DRIVE;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

endmodule
